// File: rtl/vga_pattern_gen_if.sv
// Timing-generator to pattern-generator bus: position/sync in, RGB332/sync/frame pulse out.
interface vga_pattern_gen_if #(
  parameter int unsigned POSITION_REG_MAX = 11
);
  logic [POSITION_REG_MAX:0] h_position;
  logic [POSITION_REG_MAX:0] v_position;
  logic                      visible_area;
  logic                      vga_horizontal_sync_in;
  logic                      vga_vertical_sync_in;
  logic [1:0]                pattern_select;
  logic [2:0]                vga_red;
  logic [2:0]                vga_green;
  logic [1:0]                vga_blue;
  logic                      vga_horizontal_sync;
  logic                      vga_vertical_sync;
  logic                      frame_start;

  // Timing source / board side
  modport master (
    output h_position, v_position, visible_area,
           vga_horizontal_sync_in, vga_vertical_sync_in, pattern_select,
    input  vga_red, vga_green, vga_blue,
           vga_horizontal_sync, vga_vertical_sync, frame_start
  );

  // Pattern generator side
  modport slave (
    input  h_position, v_position, visible_area,
           vga_horizontal_sync_in, vga_vertical_sync_in, pattern_select,
    output vga_red, vga_green, vga_blue,
           vga_horizontal_sync, vga_vertical_sync, frame_start
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// RGB332 test-pattern source (bars, checker, bouncing box, gradient) with a 2-cycle pixel pipeline.
// Optional: define VGA_PATTERN_BORDER_EN to force a white 1-pixel frame border in every mode.
module vga_pattern_gen #(
  parameter int unsigned WIDTH             = 1280,
  parameter int unsigned HEIGHT            = 800,
  parameter int unsigned POSITION_REG_MAX  = 11,
  parameter logic        H_ACTIVE_POLARITY = 1'b0,
  parameter logic        V_ACTIVE_POLARITY = 1'b1,
  parameter int unsigned CHECK_SHIFT       = 5,
  parameter int unsigned BOX_SIZE          = 64,
  parameter int unsigned BOX_STEP          = 4
) (
  input logic            pixel_clock,
  input logic            reset,
  vga_pattern_gen_if.slave vga
);

  localparam int unsigned PW = POSITION_REG_MAX + 1;
  typedef logic [PW-1:0] pos_t;
  typedef logic [PW:0]   pos_ext_t;

  localparam pos_t BAR_1 = pos_t'(WIDTH * 1 / 8);
  localparam pos_t BAR_2 = pos_t'(WIDTH * 2 / 8);
  localparam pos_t BAR_3 = pos_t'(WIDTH * 3 / 8);
  localparam pos_t BAR_4 = pos_t'(WIDTH * 4 / 8);
  localparam pos_t BAR_5 = pos_t'(WIDTH * 5 / 8);
  localparam pos_t BAR_6 = pos_t'(WIDTH * 6 / 8);
  localparam pos_t BAR_7 = pos_t'(WIDTH * 7 / 8);

  localparam pos_t     FRAME_LINE = pos_t'(HEIGHT);
  localparam pos_t     BOX_X_MAX  = pos_t'(WIDTH - BOX_SIZE);
  localparam pos_t     BOX_Y_MAX  = pos_t'(HEIGHT - BOX_SIZE);
  localparam pos_t     STEP       = pos_t'(BOX_STEP);
  localparam pos_ext_t X_LIMIT    = pos_ext_t'(WIDTH);
  localparam pos_ext_t Y_LIMIT    = pos_ext_t'(HEIGHT);
  localparam pos_ext_t REACH      = pos_ext_t'(BOX_SIZE + BOX_STEP);
  localparam pos_ext_t SIZE_EXT   = pos_ext_t'(BOX_SIZE);
`ifdef VGA_PATTERN_BORDER_EN
  localparam pos_t     H_LAST     = pos_t'(WIDTH - 1);
  localparam pos_t     V_LAST     = pos_t'(HEIGHT - 1);
`endif

  localparam logic [7:0] WHITE = 8'hFF;
  localparam logic [7:0] BLUE  = 8'h03;

  pos_t       h;
  pos_t       v;
  logic [1:0] mode;
  pos_t       box_x;
  pos_t       box_y;
  logic       dir_x_neg;
  logic       dir_y_neg;
  logic [7:0] frame_count;

  pos_t       box_x_nxt;
  pos_t       box_y_nxt;
  logic       dir_x_neg_nxt;
  logic       dir_y_neg_nxt;
  logic       frame_event_c;

  logic [2:0] bar_idx;
  logic       checker_on;
  logic       in_box_x;
  logic       in_box_y;
  logic [7:0] pix_c;

  logic [7:0] pix_s1;
  logic       vis_s1;
  logic       hs_s1;
  logic       vs_s1;

  assign h = vga.h_position;
  assign v = vga.v_position;

  // Start of vertical blanking: the only point where mode and box may change.
  assign frame_event_c = (h == '0) && (v == FRAME_LINE);

  // Bounce the box off the right/bottom and left/top edges without wrapping.
  always_comb begin
    box_x_nxt     = box_x;
    box_y_nxt     = box_y;
    dir_x_neg_nxt = dir_x_neg;
    dir_y_neg_nxt = dir_y_neg;

    if (!dir_x_neg) begin
      if ({1'b0, box_x} + REACH >= X_LIMIT) begin
        box_x_nxt     = BOX_X_MAX;
        dir_x_neg_nxt = 1'b1;
      end else begin
        box_x_nxt = box_x + STEP;
      end
    end else begin
      if (box_x <= STEP) begin
        box_x_nxt     = '0;
        dir_x_neg_nxt = 1'b0;
      end else begin
        box_x_nxt = box_x - STEP;
      end
    end

    if (!dir_y_neg) begin
      if ({1'b0, box_y} + REACH >= Y_LIMIT) begin
        box_y_nxt     = BOX_Y_MAX;
        dir_y_neg_nxt = 1'b1;
      end else begin
        box_y_nxt = box_y + STEP;
      end
    end else begin
      if (box_y <= STEP) begin
        box_y_nxt     = '0;
        dir_y_neg_nxt = 1'b0;
      end else begin
        box_y_nxt = box_y - STEP;
      end
    end
  end

  // Bar index from fixed boundaries, no divider.
  always_comb begin
    bar_idx = 3'd0;
    if (h >= BAR_1) bar_idx = 3'd1;
    if (h >= BAR_2) bar_idx = 3'd2;
    if (h >= BAR_3) bar_idx = 3'd3;
    if (h >= BAR_4) bar_idx = 3'd4;
    if (h >= BAR_5) bar_idx = 3'd5;
    if (h >= BAR_6) bar_idx = 3'd6;
    if (h >= BAR_7) bar_idx = 3'd7;
  end

  assign checker_on = h[CHECK_SHIFT] ^ v[CHECK_SHIFT];
  assign in_box_x   = ({1'b0, h} >= {1'b0, box_x}) && ({1'b0, h} < {1'b0, box_x} + SIZE_EXT);
  assign in_box_y   = ({1'b0, v} >= {1'b0, box_y}) && ({1'b0, v} < {1'b0, box_y} + SIZE_EXT);

  // Pattern colour for the current input pixel, using the frame-latched mode.
  always_comb begin
    pix_c = 8'h00;
    unique case (mode)
      2'b00:   pix_c = {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {2{bar_idx[0]}}};
      2'b01:   pix_c = checker_on ? WHITE : 8'h00;
      2'b10:   pix_c = (in_box_x && in_box_y) ? WHITE : BLUE;
      default: pix_c = {h[7:5], v[7:5], frame_count[7:6]};
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if ((h == '0) || (h == H_LAST) || (v == '0) || (v == V_LAST)) begin
      pix_c = WHITE;
    end
`endif
  end

  // Frame-rate state: latched mode, box position and frame counter.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      mode            <= 2'b00;
      box_x           <= '0;
      box_y           <= '0;
      dir_x_neg       <= 1'b0;
      dir_y_neg       <= 1'b0;
      frame_count     <= 8'd0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.frame_start <= frame_event_c;
      if (frame_event_c) begin
        mode        <= vga.pattern_select;
        box_x       <= box_x_nxt;
        box_y       <= box_y_nxt;
        dir_x_neg   <= dir_x_neg_nxt;
        dir_y_neg   <= dir_y_neg_nxt;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Two-stage pixel pipeline; syncs travel alongside so pins stay aligned.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      pix_s1                  <= 8'h00;
      vis_s1                  <= 1'b0;
      hs_s1                   <= ~H_ACTIVE_POLARITY;
      vs_s1                   <= ~V_ACTIVE_POLARITY;
      vga.vga_red             <= 3'd0;
      vga.vga_green           <= 3'd0;
      vga.vga_blue            <= 2'd0;
      vga.vga_horizontal_sync <= ~H_ACTIVE_POLARITY;
      vga.vga_vertical_sync   <= ~V_ACTIVE_POLARITY;
    end else begin
      pix_s1                  <= pix_c;
      vis_s1                  <= vga.visible_area;
      hs_s1                   <= vga.vga_horizontal_sync_in;
      vs_s1                   <= vga.vga_vertical_sync_in;
      vga.vga_red             <= vis_s1 ? pix_s1[7:5] : 3'd0;
      vga.vga_green           <= vis_s1 ? pix_s1[4:2] : 3'd0;
      vga.vga_blue            <= vis_s1 ? pix_s1[1:0] : 2'd0;
      vga.vga_horizontal_sync <= hs_s1;
      vga.vga_vertical_sync   <= vs_s1;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: positions driven directly, expected colours hand-computed.
module tb_vga_pattern_gen;

  logic pixel_clock = 1'b0;
  logic reset;

  vga_pattern_gen_if #(.POSITION_REG_MAX(11)) vif ();

  vga_pattern_gen dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .vga         (vif)
  );

  always #5 pixel_clock = ~pixel_clock;

  int errors = 0;
  int checks = 0;

  // Reference box/frame model
  int mx  = 0;
  int my  = 0;
  bit mdx = 1'b0;
  bit mdy = 1'b0;
  int fc  = 0;
  int max_box_x = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pixel_clock);
    #1;
  endtask

  function automatic logic [7:0] px_exp(input int h, input int v, input logic [7:0] base);
`ifdef VGA_PATTERN_BORDER_EN
    if (h == 0 || h == 1279 || v == 0 || v == 799) return 8'hFF;
`endif
    return base;
  endfunction

  function automatic logic [7:0] rgb;
    return {vif.vga_red, vif.vga_green, vif.vga_blue};
  endfunction

  task automatic drive(input int h, input int v, input logic vis, input logic hs, input logic vs);
    vif.h_position             = 12'(h);
    vif.v_position             = 12'(v);
    vif.visible_area           = vis;
    vif.vga_horizontal_sync_in = hs;
    vif.vga_vertical_sync_in   = vs;
  endtask

  // Hold one pixel for two edges, then compare the pipelined colour.
  task automatic probe(input string tag, input int h, input int v, input logic vis, input logic [7:0] base);
    drive(h, v, vis, 1'b1, 1'b0);
    tick;
    tick;
    check(tag, 32'(rgb()), 32'(vis ? px_exp(h, v, base) : 8'h00));
  endtask

  task automatic model_step;
    if (!mdx) begin
      if (mx + 64 + 4 >= 1280) begin mx = 1216; mdx = 1'b1; end
      else mx = mx + 4;
    end else begin
      if (mx <= 4) begin mx = 0; mdx = 1'b0; end
      else mx = mx - 4;
    end
    if (!mdy) begin
      if (my + 64 + 4 >= 800) begin my = 736; mdy = 1'b1; end
      else my = my + 4;
    end else begin
      if (my <= 4) begin my = 0; mdy = 1'b0; end
      else my = my - 4;
    end
    fc = (fc + 1) % 256;
  endtask

  // Present the frame event for one cycle and check the one-cycle pulse.
  task automatic frame(input logic [1:0] sel);
    vif.pattern_select = sel;
    drive(0, 800, 1'b0, 1'b1, 1'b1);
    tick;
    check("frame_start_hi", 32'(vif.frame_start), 32'd1);
    drive(1, 800, 1'b0, 1'b1, 1'b1);
    tick;
    check("frame_start_lo", 32'(vif.frame_start), 32'd0);
    model_step();
  endtask

  initial begin
    vif.pattern_select = 2'b00;
    drive(0, 0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;

    // Reset held while the inputs keep moving, including a frame event
    for (int i = 0; i < 6; i++) begin
      if (i == 3) drive(0, 800, 1'b0, 1'b0, 1'b1);
      else        drive(1200 + i, 10, 1'b1, 1'b0, 1'b1);
      tick;
      check("rst_rgb",   32'(rgb()), 32'h0);
      check("rst_hsync", 32'(vif.vga_horizontal_sync), 32'd1);
      check("rst_vsync", 32'(vif.vga_vertical_sync), 32'd0);
      check("rst_fs",    32'(vif.frame_start), 32'd0);
    end

    // First valid pixel two edges after release
    reset = 1'b0;
    drive(1200, 10, 1'b1, 1'b1, 1'b0);
    tick;
    check("lat_edge1", 32'(rgb()), 32'h00);
    tick;
    check("lat_edge2", 32'(rgb()), 32'hFF);

    // Mode 00 bars on line 0 and blanking
    probe("bar_0",    0,    0, 1'b1, 8'h00);
    probe("bar_159",  159,  0, 1'b1, 8'h00);
    probe("bar_160",  160,  0, 1'b1, 8'h03);
    probe("bar_319",  319,  0, 1'b1, 8'h03);
    probe("bar_640",  640,  5, 1'b1, 8'hE0);
    probe("bar_1120", 1120, 0, 1'b1, 8'hFF);
    probe("bar_1279", 1279, 0, 1'b1, 8'hFF);
    probe("blank_1300", 1300, 0, 1'b0, 8'h00);
    probe("blank_1679", 1679, 0, 1'b0, 8'h00);

    // Sync lag of exactly two edges
    drive(1300, 10, 1'b0, 1'b1, 1'b0);
    tick; tick;
    drive(1300, 10, 1'b0, 1'b0, 1'b0);
    tick; check("hs_fall_e1", 32'(vif.vga_horizontal_sync), 32'd1);
    tick; check("hs_fall_e2", 32'(vif.vga_horizontal_sync), 32'd0);
    drive(1300, 10, 1'b0, 1'b1, 1'b0);
    tick; check("hs_rise_e1", 32'(vif.vga_horizontal_sync), 32'd0);
    tick; check("hs_rise_e2", 32'(vif.vga_horizontal_sync), 32'd1);
    drive(1300, 801, 1'b0, 1'b1, 1'b1);
    tick; check("vs_rise_e1", 32'(vif.vga_vertical_sync), 32'd0);
    tick; check("vs_rise_e2", 32'(vif.vga_vertical_sync), 32'd1);

    // No pulse away from the frame event
    drive(0, 799, 1'b1, 1'b1, 1'b0);
    tick; check("fs_quiet_799", 32'(vif.frame_start), 32'd0);
    drive(0, 0, 1'b1, 1'b1, 1'b0);
    tick; check("fs_quiet_0", 32'(vif.frame_start), 32'd0);

    // Mode 01 checkerboard
    frame(2'b01);
    probe("chk_0_0",   0,  0,  1'b1, 8'h00);
    probe("chk_32_0",  32, 0,  1'b1, 8'hFF);
    probe("chk_32_32", 32, 32, 1'b1, 8'h00);
    probe("chk_31_31", 31, 31, 1'b1, 8'h00);

    // Select change mid-frame takes effect only after the next frame event
    vif.pattern_select = 2'b00;
    probe("midframe_old", 32, 400, 1'b1, 8'hFF);
    frame(2'b00);
    probe("midframe_new", 32, 400, 1'b1, 8'h00);

    // Mode 10: bounce the box for 400 frames
    for (int f = 0; f < 400; f++) begin
      frame(2'b10);
      if (32'(dut.box_x) > 32'(max_box_x)) max_box_x = int'(dut.box_x);
      check("box_x", 32'(dut.box_x), 32'(mx));
      check("box_y", 32'(dut.box_y), 32'(my));
    end
    check("box_x_max", 32'(max_box_x), 32'd1216);
    probe("box_corner", mx, my, 1'b1, 8'hFF);
    probe("box_right",  mx + 64, my, 1'b1, 8'h03);
    probe("box_below",  mx, my + 64, 1'b1, 8'h03);
    probe("box_last",   mx + 63, my + 63, 1'b1, 8'hFF);

    // Mode 11 gradient
    frame(2'b11);
    probe("grad_a", 160, 96, 1'b1, {3'd5, 3'd3, 2'(fc / 64)});
    probe("grad_b", 224, 32, 1'b1, {3'd7, 3'd1, 2'(fc / 64)});
    check("frame_count", 32'(dut.frame_count), 32'(fc));

    // One-cycle reset mid-line
    drive(500, 300, 1'b1, 1'b0, 1'b1);
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mid_rst_rgb",   32'(rgb()), 32'h0);
    check("mid_rst_hsync", 32'(vif.vga_horizontal_sync), 32'd1);
    check("mid_rst_vsync", 32'(vif.vga_vertical_sync), 32'd0);
    check("mid_rst_fs",    32'(vif.frame_start), 32'd0);
    check("mid_rst_box_x", 32'(dut.box_x), 32'd0);
    check("mid_rst_box_y", 32'(dut.box_y), 32'd0);
    check("mid_rst_fc",    32'(dut.frame_count), 32'd0);
    mx = 0; my = 0; mdx = 1'b0; mdy = 1'b0; fc = 0;
    probe("post_rst_mode00", 1200, 300, 1'b1, 8'hFF);
    frame(2'b10);
    check("post_rst_box_x", 32'(dut.box_x), 32'd4);
    probe("post_rst_box", 4, 4, 1'b1, 8'hFF);

`ifdef VGA_PATTERN_BORDER_EN
    probe("border_left",   0,    400, 1'b1, 8'hFF);
    probe("border_right",  1279, 400, 1'b1, 8'hFF);
    probe("border_top",    600,  0,   1'b1, 8'hFF);
    probe("border_bottom", 600,  799, 1'b1, 8'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
